// File: rtl/instruction_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer_pkg
// Brief   : Opcodes, branch condition codes and state encoding shared by the
//           instruction sequencer and its bench.
// Revision: 1.0 - initial release
// ============================================================================
package instruction_sequencer_pkg;

    localparam int c_WAIT_LIMIT_DEFAULT = 255;

    localparam logic [3:0] c_OP_ALU0  = 4'h0;
    localparam logic [3:0] c_OP_ALU1  = 4'h1;
    localparam logic [3:0] c_OP_LOAD  = 4'h4;
    localparam logic [3:0] c_OP_STORE = 4'h5;
    localparam logic [3:0] c_OP_BCOND = 4'hC;
    localparam logic [3:0] c_OP_JUMP  = 4'hD;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    localparam logic [3:0] c_CC_ALWAYS = 4'd0;
    localparam logic [3:0] c_CC_Z      = 4'd1;
    localparam logic [3:0] c_CC_NZ     = 4'd2;
    localparam logic [3:0] c_CC_C      = 4'd3;
    localparam logic [3:0] c_CC_NC     = 4'd4;
    localparam logic [3:0] c_CC_N      = 4'd5;
    localparam logic [3:0] c_CC_NN     = 4'd6;
    localparam logic [3:0] c_CC_V      = 4'd7;

    // Bit positions inside the {N,C,Z,V} flag vector
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_C = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_V = 0;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_FETCH    = 3'd1;
    localparam logic [2:0] c_ST_DECODE   = 3'd2;
    localparam logic [2:0] c_ST_EXECUTE  = 3'd3;
    localparam logic [2:0] c_ST_MEM_WAIT = 3'd4;
    localparam logic [2:0] c_ST_HALT     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = c_ST_IDLE,
        ST_FETCH    = c_ST_FETCH,
        ST_DECODE   = c_ST_DECODE,
        ST_EXECUTE  = c_ST_EXECUTE,
        ST_MEM_WAIT = c_ST_MEM_WAIT,
        ST_HALT     = c_ST_HALT
    } state_t;

    function automatic logic [15:0] sext8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_sequencer_branch_condition_eval.sv
`default_nettype none
// ============================================================================
// Module  : branch_condition_eval
// Brief   : Combinational evaluation of a 4-bit branch condition against ALU flags.
// Revision: 1.0 - initial release
// ============================================================================
module branch_condition_eval
    import instruction_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            c_CC_ALWAYS: taken = 1'b1;
            c_CC_Z:      taken =  flags[c_FLAG_Z];
            c_CC_NZ:     taken = ~flags[c_FLAG_Z];
            c_CC_C:      taken =  flags[c_FLAG_C];
            c_CC_NC:     taken = ~flags[c_FLAG_C];
            c_CC_N:      taken =  flags[c_FLAG_N];
            c_CC_NN:     taken = ~flags[c_FLAG_N];
            c_CC_V:      taken =  flags[c_FLAG_V];
            default:     taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instruction_sequencer
// Brief   : Fetch/decode/execute control FSM with memory-wait timeout and halt.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = c_WAIT_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instruction,
    input  logic [15:0] current_pc,
    input  logic [3:0]  flags,
    input  logic [15:0] jump_target,
    input  logic        mem_ready,
    output logic        ir_load,
    output logic        pc_enable,
    output logic        pc_inc_or_set,
    output logic [15:0] pc_new_address,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic        bus_fault,
    output logic [2:0]  state_dbg
);

    localparam int c_CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_LIMIT - 1);

    state_t               r_state;
    logic [15:0]          r_ir;
    logic [c_CNT_W-1:0]   r_waitCnt;
    logic                 r_busFault;

    logic [3:0]  w_opcode;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_taken;
    logic        w_irLoad;
    logic        w_pcEnable;
    logic        w_pcSet;
    logic [15:0] w_pcNewAddress;
    logic        w_regWrite;
    logic        w_memRead;
    logic        w_memWrite;

    assign w_opcode  = r_ir[15:12];
    assign w_isLoad  = (w_opcode == c_OP_LOAD);
    assign w_isStore = (w_opcode == c_OP_STORE);

    branch_condition_eval u_branch_condition_eval (
        .cond  (r_ir[11:8]),
        .flags (flags),
        .taken (w_taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            r_waitCnt  <= '0;
            r_busFault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir    <= instruction;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (w_isLoad || w_isStore) begin
                        r_waitCnt <= '0;
                        r_state   <= ST_MEM_WAIT;
                    end else if (w_opcode == c_OP_HALT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_MEM_WAIT: begin
                    // A completion on the final allowed cycle takes priority over the timeout
                    if (mem_ready) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                        if (r_waitCnt == c_CNT_LAST) begin
                            r_busFault <= 1'b1;
                            r_state    <= ST_HALT;
                        end
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_irLoad       = 1'b0;
        w_pcEnable     = 1'b0;
        w_pcSet        = 1'b0;
        w_pcNewAddress = 16'h0000;
        w_regWrite     = 1'b0;
        w_memRead      = 1'b0;
        w_memWrite     = 1'b0;
        case (r_state)
            ST_FETCH: w_irLoad = 1'b1;
            ST_EXECUTE: begin
                case (w_opcode)
                    c_OP_ALU0, c_OP_ALU1: begin
                        w_regWrite = 1'b1;
                        w_pcEnable = 1'b1;
                    end
                    c_OP_BCOND: begin
                        w_pcEnable = 1'b1;
                        if (w_taken) begin
                            w_pcSet        = 1'b1;
                            w_pcNewAddress = current_pc + sext8(r_ir[7:0]);
                        end
                    end
                    c_OP_JUMP: begin
                        w_pcEnable     = 1'b1;
                        w_pcSet        = 1'b1;
                        w_pcNewAddress = jump_target;
                    end
                    c_OP_LOAD, c_OP_STORE, c_OP_HALT: ;
                    default: w_pcEnable = 1'b1;
                endcase
            end
            ST_MEM_WAIT: begin
                w_memRead  = w_isLoad;
                w_memWrite = w_isStore;
                if (mem_ready) begin
                    w_regWrite = w_isLoad;
                    w_pcEnable = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset masks every output immediately rather than waiting for the next edge
    assign ir_load        = w_irLoad   & ~reset;
    assign pc_enable      = w_pcEnable & ~reset;
    assign pc_inc_or_set  = w_pcSet    & ~reset;
    assign pc_new_address = reset ? 16'h0000 : w_pcNewAddress;
    assign reg_write      = w_regWrite & ~reset;
    assign mem_read       = w_memRead  & ~reset;
    assign mem_write      = w_memWrite & ~reset;
    assign halted         = (r_state == ST_HALT) & ~reset;
    assign bus_fault      = r_busFault & ~reset;
    assign state_dbg      = reset ? c_ST_IDLE : 3'(r_state);

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, SHALL set the maximum memory-wait cycles before a bus fault.
REQ-002 clock  in  1  single clock; every flop is posedge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 run  in  1  leaves IDLE when high.
REQ-005 instruction  in  16  instruction word from program memory at current_pc.
REQ-006 current_pc  in  16  program counter value.
REQ-007 flags  in  4  {N,C,Z,V} from ALU, sampled in EXECUTE.
REQ-008 jump_target  in  16  register-file read value for JUMP.
REQ-009 mem_ready  in  1  data-memory completion strobe.
REQ-010 ir_load  out  1  instruction-register load strobe.
REQ-011 pc_enable  out  1  program-counter update strobe.
REQ-012 pc_inc_or_set  out  1  0 = increment, 1 = load pc_new_address.
REQ-013 pc_new_address  out  16  branch/jump target.
REQ-014 reg_write, mem_read, mem_write  out  1 each  datapath strobes.
REQ-015 halted, bus_fault  out  1 each  status; state_dbg  out  3  current state encoding.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, HALT.
REQ-017 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-018 FETCH: ir_load=1 for exactly one cycle; -> DECODE.
REQ-019 DECODE: latch instruction[15:0] into an internal IR; no strobes; -> EXECUTE.
REQ-020 Opcode = IR[15:12]: 0x0/0x1 ALU, 0x4 LOAD, 0x5 STORE, 0xC BCOND, 0xD JUMP, 0xF HALT; all others SHALL execute as NOP.
REQ-021 EXECUTE ALU: reg_write=1, pc_enable=1, pc_inc_or_set=0 for one cycle; -> FETCH.
REQ-022 EXECUTE NOP: pc_enable=1, pc_inc_or_set=0; -> FETCH.
REQ-023 EXECUTE BCOND: cond = IR[11:8]; 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V, 8-15 never.
REQ-024 BCOND taken: pc_enable=1, pc_inc_or_set=1, pc_new_address = current_pc + sign-extended IR[7:0], modulo 2^16; not taken: increment; -> FETCH.
REQ-025 EXECUTE JUMP: pc_enable=1, pc_inc_or_set=1, pc_new_address = jump_target; -> FETCH.
REQ-026 EXECUTE LOAD/STORE: -> MEM_WAIT; wait counter cleared.
REQ-027 MEM_WAIT: mem_read (LOAD) or mem_write (STORE) held high every cycle in state.
REQ-028 MEM_WAIT with mem_ready=1: same cycle reg_write=1 (LOAD only), pc_enable=1, pc_inc_or_set=0; -> FETCH.
REQ-029 MEM_WAIT, mem_ready=0: counter increments; reaching WAIT_LIMIT -> HALT with bus_fault=1; mem_ready=1 on the limit cycle SHALL win (normal completion, no fault).
REQ-030 EXECUTE HALT: no PC update; -> HALT.
REQ-031 HALT: halted=1, all strobes 0; exits only on reset; run ignored.
REQ-032 pc_new_address SHALL be 0 whenever pc_inc_or_set=0.
REQ-033 Outputs SHALL be combinational decode of state, IR and counter only; no strobe asserts in two consecutive cycles except mem_read/mem_write in MEM_WAIT.
REQ-034 Instruction latency: non-memory = 3 cycles FETCH->FETCH; memory = 4 + wait cycles.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, IR=0, counter=0, bus_fault=0, regardless of state (including mid-MEM_WAIT).
REQ-036 During reset and in IDLE every output SHALL be 0; state_dbg = IDLE encoding.

Structure
REQ-037 Shared package: opcode constants, condition codes, state encoding, WAIT_LIMIT default.
REQ-038 One sub-module branch_condition_eval (cond, flags -> taken), purely combinational.

Verification
REQ-039 Reset then run=1, IR=0x0123 -> ir_load cycle 1, reg_write+pc_enable/inc cycle 3, back in FETCH cycle 4.
REQ-040 current_pc=0x0010, IR=0xC0FE -> pc_new_address=0x000E, pc_inc_or_set=1; with IR=0xC1FE and Z=0 -> increment only.
REQ-041 current_pc=0xFFFF, IR=0xC002 -> pc_new_address=0x0001 (wrap).
REQ-042 LOAD with mem_ready after 3 cycles -> mem_read high 4 cycles, reg_write+pc_enable on the ready cycle; STORE never raises reg_write.
REQ-043 LOAD with mem_ready stuck 0, WAIT_LIMIT=4 -> HALT, bus_fault=1, halted=1; reset=1 mid-MEM_WAIT -> IDLE, all outputs 0 next cycle.
REQ-044 IR=0xF000 -> halted=1 indefinitely, no pc_enable, run toggles ignored until reset.
